// File: rtl/peripheral_bridge_ahb3_mpi.sv
// -----------------------------------------------------------------------------
// peripheral_bridge_ahb3_mpi
//
// AHB3-Lite slave front-end for the generic single-request MPI bus. Each
// accepted NONSEQ/SEQ beat is turned into a single MPI request. The request is
// held on bus_en until the buffer answers with bus_ack or bus_err, or until
// the response timeout expires. AHB wait states are inserted while the request
// is outstanding. Failures are reported with the two-cycle AHB ERROR response.
//
// Handshake (MPI side): bus_addr/bus_we are stable while bus_en=1. The request
// completes in the cycle where bus_en=1 and bus_ack or bus_err is sampled high.
// bus_en then drops for at least one cycle before the next request is issued.
// bus_data_out is only sampled in the cycle where bus_ack is high.
//
// Ports
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   ahb3_*_i            AHB3-Lite slave inputs (hburst/hprot/hmastlock ignored)
//   ahb3_hrdata_o       read data, updated only when a read completes OK
//   ahb3_hready_o       data phase complete
//   ahb3_hresp_o        1 = ERROR
//   bus_addr, bus_we    registered transfer address / direction
//   bus_en              request active
//   bus_data_in         write data (straight from ahb3_hwdata_i)
//   bus_data_out        read data from the buffer, valid with bus_ack
//   bus_ack, bus_err    request completion status
//   fsm_state           current FSM state (IDLE=0 ACCESS=1 DONE=2 ERR1=3 ERR2=4)
// -----------------------------------------------------------------------------
module peripheral_bridge_ahb3_mpi #(
    parameter int PLEN    = 32,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            ahb3_hsel_i,
    input  logic [PLEN-1:0] ahb3_haddr_i,
    input  logic [XLEN-1:0] ahb3_hwdata_i,
    input  logic            ahb3_hwrite_i,
    input  logic [2:0]      ahb3_hsize_i,
    input  logic [2:0]      ahb3_hburst_i,
    input  logic [3:0]      ahb3_hprot_i,
    input  logic [1:0]      ahb3_htrans_i,
    input  logic            ahb3_hmastlock_i,
    input  logic            ahb3_hready_i,
    output logic [XLEN-1:0] ahb3_hrdata_o,
    output logic            ahb3_hready_o,
    output logic            ahb3_hresp_o,

    output logic [31:0]     bus_addr,
    output logic            bus_we,
    output logic            bus_en,
    output logic [31:0]     bus_data_in,
    input  logic [31:0]     bus_data_out,
    input  logic            bus_ack,
    input  logic            bus_err,

    output logic [2:0]      fsm_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_DONE   = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_t;

    // A zero TIMEOUT still needs a 1-bit counter to keep the code legal.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              ack_q;    // buffer answered OK, finish next cycle
    logic              err_q;    // buffer answered with an error
    logic [XLEN-1:0]   rdata_q;  // read data captured with bus_ack
    logic              acc;
    logic              size_ok;
    logic              timed_out;

    // Beats and attributes the bridge does not act on.
    logic unused_inputs;
    assign unused_inputs = ^{ahb3_hburst_i, ahb3_hprot_i, ahb3_hmastlock_i,
                             ahb3_htrans_i[0]};

    assign acc         = ahb3_hsel_i & ahb3_hready_i & ahb3_htrans_i[1] & ahb3_hready_o;
    assign size_ok     = (ahb3_hsize_i == 3'b010);
    assign timed_out   = (TIMEOUT != 0) && (cnt == CNT_LIM);
    assign bus_data_in = ahb3_hwdata_i;
    assign fsm_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ahb3_hready_o <= 1'b1;
            ahb3_hresp_o  <= 1'b0;
            ahb3_hrdata_o <= '0;
            bus_en        <= 1'b0;
            bus_we        <= 1'b0;
            bus_addr      <= '0;
            cnt           <= '0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            rdata_q       <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (acc) begin
                        bus_addr      <= ahb3_haddr_i[31:0];
                        bus_we        <= ahb3_hwrite_i;
                        ahb3_hready_o <= 1'b0;
                        if (!size_ok) begin
                            // Unsupported size: answer ERROR without touching the bus.
                            state        <= ST_ERR1;
                            ahb3_hresp_o <= 1'b1;
                        end else begin
                            state        <= ST_ACCESS;
                            ahb3_hresp_o <= 1'b0;
                            bus_en       <= 1'b1;
                            cnt          <= '0;
                            ack_q        <= 1'b0;
                            err_q        <= 1'b0;
                        end
                    end else begin
                        state         <= ST_IDLE;
                        ahb3_hready_o <= 1'b1;
                        ahb3_hresp_o  <= 1'b0;
                    end
                end

                ST_ACCESS: begin
                    if (bus_en) begin
                        // Request outstanding. err has priority over ack,
                        // and either one has priority over the timeout.
                        if (bus_err) begin
                            bus_en <= 1'b0;
                            err_q  <= 1'b1;
                        end else if (bus_ack) begin
                            bus_en  <= 1'b0;
                            ack_q   <= 1'b1;
                            rdata_q <= bus_data_out;
                        end else if (timed_out) begin
                            bus_en       <= 1'b0;
                            state        <= ST_ERR1;
                            ahb3_hresp_o <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (err_q || !ack_q) begin
                        // Request ended with an error; start the ERROR response.
                        state        <= ST_ERR1;
                        ahb3_hresp_o <= 1'b1;
                    end else begin
                        // Request ended OK; complete the data phase.
                        state         <= ST_DONE;
                        ahb3_hready_o <= 1'b1;
                        ahb3_hresp_o  <= 1'b0;
                        if (!bus_we) begin
                            ahb3_hrdata_o <= rdata_q;
                        end
                    end
                end

                ST_ERR1: begin
                    state         <= ST_ERR2;
                    ahb3_hready_o <= 1'b1;
                    ahb3_hresp_o  <= 1'b1;
                end

                default: begin
                    state         <= ST_IDLE;
                    ahb3_hready_o <= 1'b1;
                    ahb3_hresp_o  <= 1'b0;
                    bus_en        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_bridge_ahb3_mpi.sv
// -----------------------------------------------------------------------------
// tb_peripheral_bridge_ahb3_mpi
//
// Directed bench for the AHB3-Lite to MPI bridge (TIMEOUT=4). The bench acts as
// both AHB master and MPI buffer. Expected {hresp, hrdata} for each transfer is
// queued when the address phase is driven and compared when hready_o returns.
// -----------------------------------------------------------------------------
module tb_peripheral_bridge_ahb3_mpi;

    localparam int W = 33;

    // Responder modes
    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_NONE = 2;
    localparam int M_BOTH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic        hready_i;
    logic [31:0] hrdata;
    logic        hready_o;
    logic        hresp;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic        bus_en;
    logic [31:0] bus_data_in;
    logic [31:0] bus_data_out;
    logic        bus_ack;
    logic        bus_err;
    logic [2:0]  fsm_state;

    logic [W-1:0] exp_q[$];
    int n_assert = 0;
    int n_fail   = 0;

    peripheral_bridge_ahb3_mpi #(
        .PLEN(32), .XLEN(32), .TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ahb3_hsel_i(hsel), .ahb3_haddr_i(haddr), .ahb3_hwdata_i(hwdata),
        .ahb3_hwrite_i(hwrite), .ahb3_hsize_i(hsize), .ahb3_hburst_i(hburst),
        .ahb3_hprot_i(hprot), .ahb3_htrans_i(htrans), .ahb3_hmastlock_i(hmastlock),
        .ahb3_hready_i(hready_i), .ahb3_hrdata_o(hrdata), .ahb3_hready_o(hready_o),
        .ahb3_hresp_o(hresp),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_en(bus_en),
        .bus_data_in(bus_data_in), .bus_data_out(bus_data_out),
        .bus_ack(bus_ack), .bus_err(bus_err),
        .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Drive an address phase; accepted on the next rising edge.
    task automatic addr_phase(input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel   = 1'b1;
        haddr  = a;
        hwrite = wr;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    // Wait for the accepting edge, then run the data phase while acting as the
    // MPI buffer. Returns at the falling edge of the cycle with hready_o=1.
    task automatic data_phase(
        input  int          mode,
        input  int          dly,
        input  logic [31:0] wdata,
        input  logic [31:0] rdata,
        output int          waits,
        output int          en_cnt,
        output logic        err1_seen,
        output logic        we_seen,
        output logic [31:0] addr_seen,
        output logic [31:0] din_seen,
        output logic        gap_ok
    );
        logic [W-1:0] exp;
        logic         done;
        waits     = 0;
        en_cnt    = 0;
        err1_seen = 1'b0;
        we_seen   = 1'bx;
        addr_seen = 'x;
        din_seen  = 'x;
        gap_ok    = 1'b0;
        done      = 1'b0;
        @(posedge clk);
        #1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hwdata = wdata;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) din_seen = bus_data_in;
            if (hready_o === 1'b1) begin
                done    = 1'b1;
                gap_ok  = (bus_en === 1'b0);
                bus_ack = 1'b0;
                bus_err = 1'b0;
            end else begin
                waits++;
                if (hresp === 1'b1) err1_seen = 1'b1;
                if (bus_en === 1'b1) begin
                    en_cnt++;
                    if (en_cnt == 1) begin
                        we_seen   = bus_we;
                        addr_seen = bus_addr;
                    end
                    if (en_cnt == dly && mode != M_NONE) begin
                        bus_ack      = (mode == M_ACK) || (mode == M_BOTH);
                        bus_err      = (mode == M_ERR) || (mode == M_BOTH);
                        bus_data_out = rdata;
                    end else begin
                        bus_ack = 1'b0;
                        bus_err = 1'b0;
                    end
                end else begin
                    bus_ack = 1'b0;
                    bus_err = 1'b0;
                end
            end
        end
        chk("data_phase_completes", {32'd0, done}, {32'd0, 1'b1});
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 33'd0, 33'd1);
        end else begin
            exp = exp_q.pop_front();
            chk("resp_rdata", {hresp, hrdata}, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    int          waits, en_cnt;
    logic        err1_seen, we_seen, gap_ok;
    logic [31:0] addr_seen, din_seen, last_rd, rnd_data;
    int          rnd_dly;

    initial begin
        rst = 1'b1; hsel = 1'b0; haddr = '0; hwdata = '0; hwrite = 1'b0;
        hsize = 3'b010; hburst = 3'b000; hprot = 4'b0011; htrans = 2'b00;
        hmastlock = 1'b0; hready_i = 1'b1;
        bus_data_out = '0; bus_ack = 1'b0; bus_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_hready", {32'd0, hready_o}, 33'd1);
        chk("rst_hresp",  {32'd0, hresp},    33'd0);
        chk("rst_hrdata", {1'b0, hrdata},    33'd0);
        chk("rst_bus_en", {32'd0, bus_en},   33'd0);
        chk("rst_bus_we", {32'd0, bus_we},   33'd0);
        chk("rst_bus_addr", {1'b0, bus_addr}, 33'd0);
        chk("rst_state",  {30'd0, fsm_state}, 33'd0);

        // Read 0x10, ack on the 3rd bus_en cycle
        last_rd = 32'hCAFE0001;
        exp_q.push_back({1'b0, last_rd});
        addr_phase(32'h10, 1'b0, 3'b010);
        data_phase(M_ACK, 3, '0, 32'hCAFE0001, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("rd10_waits", 33'(waits), 33'd4);
        chk("rd10_en_cycles", 33'(en_cnt), 33'd3);
        chk("rd10_addr", {1'b0, addr_seen}, {1'b0, 32'h10});
        chk("rd10_we", {32'd0, we_seen}, 33'd0);

        // Back-to-back: write 0x0 then read 0x4 presented in the DONE cycle
        exp_q.push_back({1'b0, last_rd});
        addr_phase(32'h0, 1'b1, 3'b010);
        data_phase(M_ACK, 1, 32'hA5A5A5A5, 32'hDEADBEEF, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("wr0_we", {32'd0, we_seen}, 33'd1);
        chk("wr0_addr", {1'b0, addr_seen}, 33'd0);
        chk("wr0_data_in", {1'b0, din_seen}, {1'b0, 32'hA5A5A5A5});
        chk("wr0_en_cycles", 33'(en_cnt), 33'd1);
        chk("wr0_waits", 33'(waits), 33'd2);
        chk("wr0_gap", {32'd0, gap_ok}, 33'd1);
        last_rd = 32'h12345678;
        exp_q.push_back({1'b0, last_rd});
        addr_phase(32'h4, 1'b0, 3'b010);
        data_phase(M_ACK, 1, '0, 32'h12345678, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("rd4_we", {32'd0, we_seen}, 33'd0);
        chk("rd4_addr", {1'b0, addr_seen}, 33'd4);
        chk("rd4_en_cycles", 33'(en_cnt), 33'd1);
        chk("rd4_waits", 33'(waits), 33'd2);
        repeat (2) @(negedge clk);

        // bus_err during a write
        exp_q.push_back({1'b1, last_rd});
        addr_phase(32'h20, 1'b1, 3'b010);
        data_phase(M_ERR, 2, 32'h0BADF00D, '0, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("wrerr_err1", {32'd0, err1_seen}, 33'd1);
        chk("wrerr_en_cycles", 33'(en_cnt), 33'd2);
        @(negedge clk);
        chk("wrerr_back_idle", {32'd0, hresp}, 33'd0);

        // Unsupported size: no bus access, two-cycle ERROR
        exp_q.push_back({1'b1, last_rd});
        addr_phase(32'h30, 1'b0, 3'b000);
        data_phase(M_ACK, 1, '0, 32'h55555555, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("size_en_cycles", 33'(en_cnt), 33'd0);
        chk("size_err1", {32'd0, err1_seen}, 33'd1);
        chk("size_waits", 33'(waits), 33'd1);
        @(negedge clk);

        // Timeout with ack withheld: bus_en high TIMEOUT+1 = 5 cycles
        exp_q.push_back({1'b1, last_rd});
        addr_phase(32'h40, 1'b0, 3'b010);
        data_phase(M_NONE, 0, '0, '0, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("tmo_en_cycles", 33'(en_cnt), 33'd5);
        chk("tmo_err1", {32'd0, err1_seen}, 33'd1);
        @(negedge clk);

        // ack and err together: error wins
        exp_q.push_back({1'b1, last_rd});
        addr_phase(32'h44, 1'b0, 3'b010);
        data_phase(M_BOTH, 1, '0, 32'h77777777, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
        chk("both_en_cycles", 33'(en_cnt), 33'd1);
        chk("both_err1", {32'd0, err1_seen}, 33'd1);
        @(negedge clk);

        // Random reads
        for (int i = 0; i < 3; i++) begin
            rnd_data = $urandom;
            rnd_dly  = $urandom_range(1, 4);
            last_rd  = rnd_data;
            exp_q.push_back({1'b0, rnd_data});
            addr_phase(32'h100 + 32'(i * 4), 1'b0, 3'b010);
            data_phase(M_ACK, rnd_dly, '0, rnd_data, waits, en_cnt, err1_seen, we_seen, addr_seen, din_seen, gap_ok);
            chk("rnd_waits", 33'(waits), 33'(rnd_dly + 1));
            chk("rnd_en_cycles", 33'(en_cnt), 33'(rnd_dly));
        end

        // Reset while a request is outstanding
        addr_phase(32'h50, 1'b0, 3'b010);
        @(posedge clk);
        #1;
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("mid_bus_en", {32'd0, bus_en}, 33'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus_en", {32'd0, bus_en}, 33'd0);
        chk("mid_rst_hready", {32'd0, hready_o}, 33'd1);
        chk("mid_rst_state", {30'd0, fsm_state}, 33'd0);
        chk("mid_rst_hrdata", {1'b0, hrdata}, 33'd0);
        rst = 1'b0;

        // IDLE and BUSY beats give zero-wait OKAY
        hsel = 1'b1; haddr = 32'h60; hwrite = 1'b0; hsize = 3'b010;
        htrans = 2'b00;
        @(negedge clk);
        chk("idle_hready", {32'd0, hready_o}, 33'd1);
        chk("idle_hresp", {32'd0, hresp}, 33'd0);
        chk("idle_bus_en", {32'd0, bus_en}, 33'd0);
        htrans = 2'b01;
        @(negedge clk);
        chk("busy_hready", {32'd0, hready_o}, 33'd1);
        chk("busy_hresp", {32'd0, hresp}, 33'd0);
        chk("busy_bus_en", {32'd0, bus_en}, 33'd0);
        hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);

        chk("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
